ifu_ibuf: RTL
=============

IFU_IBUF -- requirements
Module: ifu_ibuf

Interface
REQ-001 SHALL have parameter: IBUF_DEPTH, 8, number of entries; power of two, at least 2.
REQ-002 SHALL have parameter: IBUF_PTR_W, 3, pointer width, equal to log2(IBUF_DEPTH).
REQ-003 SHALL have port: clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst_clk  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port: rtu_global_flush  in  1  pipeline flush from retire.
REQ-006 SHALL have port: ifu_ibuf_inst_vld  in  1  fetch offers one instruction this cycle.
REQ-007 SHALL have port: ifu_ibuf_inst_pc  in  64  PC of the offered instruction.
REQ-008 SHALL have port: ifu_ibuf_inst  in  32  offered instruction word.
REQ-009 SHALL have port: y_idu_id_stall_ctrl  in  1  decode stall; decode does not consume while high.
REQ-010 SHALL have port: ibuf_ifu_full  out  1  buffer full; fetch must hold the offer.
REQ-011 SHALL have port: ifu_idu_id_inst_vld  out  1  instruction presented to decode.
REQ-012 SHALL have port: ifu_idu_id_inst_pc  out  64  PC presented to decode.
REQ-013 SHALL have port: ifu_idu_id_inst  out  32  instruction word presented to decode.
REQ-014 SHALL have port: ibuf_cnt  out  IBUF_PTR_W+1  current occupancy.

Function
REQ-015 SHALL be a circular FIFO with write pointer wptr, read pointer rptr and occupancy counter cnt; storage is registers, one entry per instruction ({pc, inst}).
REQ-016 SHALL assert ibuf_ifu_full combinationally exactly when cnt == IBUF_DEPTH; the signal does not depend on a same-cycle pop.
REQ-017 SHALL define push = ifu_ibuf_inst_vld & !ibuf_ifu_full & !rtu_global_flush; an offer while full is dropped, and fetch is responsible for re-offering it.
REQ-018 SHALL define pop = ifu_idu_id_inst_vld & !y_idu_id_stall_ctrl & !rtu_global_flush.
REQ-019 SHALL drive ifu_idu_id_inst_vld = (cnt != 0), with pc and inst taken combinationally from the entry at rptr (bypass case: see REQ-029).
REQ-020 SHALL drive the pc and inst outputs to 0 when ifu_idu_id_inst_vld is low.
REQ-021 SHALL, on push, write the entry at wptr and advance wptr by 1 modulo IBUF_DEPTH.
REQ-022 SHALL, on pop, advance rptr by 1 modulo IBUF_DEPTH.
REQ-023 SHALL update cnt as: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-024 SHALL, without bypass, have a latency of 1 cycle: an instruction pushed at edge N is visible to decode after edge N.
REQ-025 SHALL, on rtu_global_flush, clear wptr, rptr and cnt at the next edge and ignore any same-cycle push and pop; entry contents are left unchanged.
REQ-026 SHALL keep head data stable while ifu_idu_id_inst_vld is high and y_idu_id_stall_ctrl is high.

Reset
REQ-027 SHALL, while rst_clk is low, hold wptr = 0, rptr = 0 and cnt = 0, so that ibuf_ifu_full = 0, ifu_idu_id_inst_vld = 0, pc = 0, inst = 0 and ibuf_cnt = 0.
REQ-028 SHALL not reset the storage array; an assertion of reset mid-operation discards all entries.

Configuration
REQ-029 SHALL, with IFU_IBUF_BYPASS_EN defined, forward an offer combinationally to the decode outputs when cnt == 0, ifu_ibuf_inst_vld = 1, y_idu_id_stall_ctrl = 0 and rtu_global_flush = 0. In that case ifu_idu_id_inst_vld = 1, no entry is written, and pointers and cnt are unchanged.
REQ-030 SHALL, with IFU_IBUF_BYPASS_EN defined and cnt == 0 but stall high, perform a normal push.
REQ-031 SHALL, without IFU_IBUF_BYPASS_EN, contain no path from the ifu_ibuf_* inputs to the decode outputs.

Verification
REQ-032 SHALL cover fill: 8 consecutive pushes with stall = 1 -> cnt = 8, full = 1; a 9th offer (pc = 0x1020) is dropped and cnt stays 8.
REQ-033 SHALL cover ordering and wrap: push pc 0x1000..0x101C, drain, push pc 0x2000..0x2008 -> decode receives the PCs in order and wptr wraps to 3.
REQ-034 SHALL cover simultaneous push and pop with cnt = 3 and stall = 0 -> cnt stays 3 and the head advances by one entry.
REQ-035 SHALL cover flush with cnt = 5 while push and pop are both active -> next cycle cnt = 0, vld = 0, and the pushed word is absent.
REQ-036 SHALL cover bypass: empty buffer, inst = 0x00000013 at pc 0x3000, stall = 0 -> with the macro, vld = 1 in the same cycle and cnt stays 0; without the macro, vld = 1 one cycle later and cnt = 1.
REQ-037 SHALL cover reset asserted with cnt = 4 -> all outputs 0 immediately; after release, the first push appears after 1 edge.

Source files
------------

// File: rtl/ifu_ibuf.sv
// ---------------------------------------------------------------------------
// ifu_ibuf -- instruction buffer between fetch and decode.
//
// A circular FIFO of {pc, inst} entries held in plain registers. Fetch offers
// one instruction per cycle. Decode sees the head entry combinationally and
// consumes it unless it is stalling. A retire flush empties the buffer.
//
// Optional feature (compile-time macro IFU_IBUF_BYPASS_EN):
//   When the buffer is empty and decode is not stalling, an offer is
//   forwarded straight to the decode outputs instead of being written.
//   Without the macro there is no combinational path from the fetch inputs
//   to the decode outputs.
//
// Ports:
//   clk                  clock, rising edge
//   rst_clk              asynchronous active-low reset (pointers and count)
//   rtu_global_flush     flush from retire; clears pointers and count
//   ifu_ibuf_inst_vld    fetch offers an instruction this cycle
//   ifu_ibuf_inst_pc     64-bit PC of the offer
//   ifu_ibuf_inst        32-bit instruction word of the offer
//   y_idu_id_stall_ctrl  decode stall; no consumption while high
//   ibuf_ifu_full        buffer full; fetch must hold its offer
//   ifu_idu_id_inst_vld  instruction presented to decode
//   ifu_idu_id_inst_pc   PC presented to decode (0 when not valid)
//   ifu_idu_id_inst      instruction presented to decode (0 when not valid)
//   ibuf_cnt             current occupancy
// ---------------------------------------------------------------------------
module ifu_ibuf #(
  parameter int IBUF_DEPTH = 8,
  parameter int IBUF_PTR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_clk,
  input  logic                  rtu_global_flush,
  input  logic                  ifu_ibuf_inst_vld,
  input  logic [63:0]           ifu_ibuf_inst_pc,
  input  logic [31:0]           ifu_ibuf_inst,
  input  logic                  y_idu_id_stall_ctrl,
  output logic                  ibuf_ifu_full,
  output logic                  ifu_idu_id_inst_vld,
  output logic [63:0]           ifu_idu_id_inst_pc,
  output logic [31:0]           ifu_idu_id_inst,
  output logic [IBUF_PTR_W:0]   ibuf_cnt
);

  localparam int ENTRY_W = 96;

  logic [IBUF_PTR_W-1:0] wptr;
  logic [IBUF_PTR_W-1:0] rptr;
  logic [IBUF_PTR_W:0]   cnt;
  logic [ENTRY_W-1:0]    mem [IBUF_DEPTH];

  logic head_vld;
  logic bypass;
  logic push;
  logic pop;

  assign head_vld      = (cnt != '0);
  assign ibuf_ifu_full = (cnt == (IBUF_PTR_W+1)'(IBUF_DEPTH));
  assign ibuf_cnt      = cnt;

`ifdef IFU_IBUF_BYPASS_EN
  assign bypass = ~head_vld & ifu_ibuf_inst_vld & ~y_idu_id_stall_ctrl &
                  ~rtu_global_flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed offer is consumed by decode directly and never stored.
  assign push = ifu_ibuf_inst_vld & ~ibuf_ifu_full & ~rtu_global_flush & ~bypass;
  // Only a stored head entry advances rptr; a bypassed offer does not.
  assign pop  = head_vld & ~y_idu_id_stall_ctrl & ~rtu_global_flush;

  always_comb begin
    ifu_idu_id_inst_vld = head_vld | bypass;
    ifu_idu_id_inst_pc  = '0;
    ifu_idu_id_inst     = '0;
    if (head_vld) begin
      {ifu_idu_id_inst_pc, ifu_idu_id_inst} = mem[rptr];
    end
`ifdef IFU_IBUF_BYPASS_EN
    else if (bypass) begin
      ifu_idu_id_inst_pc = ifu_ibuf_inst_pc;
      ifu_idu_id_inst    = ifu_ibuf_inst;
    end
`endif
  end

  // ---- storage register boundary: data only, never reset ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {ifu_ibuf_inst_pc, ifu_ibuf_inst};
    end
  end

  // ---- control register boundary: pointers and occupancy ----
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (rtu_global_flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the modulo wrap.
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
